// File: rtl/unisim_sram_b_param_1wnr_if.sv
// Bus bundle for the parametrised 1-write / NRD-read banked BRAM wrapper.
// The master drives write and read requests. The slave (the memory) returns
// write-ready, read data and the conflict counter.
interface unisim_sram_b_param_1wnr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int NRD    = 2,
  parameter int CNT_W  = 16
);
  logic                     CE0;
  logic                     WE0;
  logic [ADDR_W-1:0]        A0;
  logic [DATA_W-1:0]        D0;
  logic [DATA_W-1:0]        WEM0;
  logic                     RDY0;
  logic [NRD-1:0]           CE1;
  logic [NRD*ADDR_W-1:0]    A1;
  logic [NRD*DATA_W-1:0]    Q1;
  logic [NRD-1:0]           QV1;
  logic [CNT_W-1:0]         CONFLICT_CNT;

  modport master (
    output CE0, WE0, A0, D0, WEM0, CE1, A1,
    input  RDY0, Q1, QV1, CONFLICT_CNT
  );

  modport slave (
    input  CE0, WE0, A0, D0, WEM0, CE1, A1,
    output RDY0, Q1, QV1, CONFLICT_CNT
  );
endinterface

// File: rtl/unisim_sram_b_param_1wnr.sv
// Parametrised banked BRAM wrapper with one write port and NRD read ports.
// Storage is built from 2048x8 banks: DATA_W/8 columns, 2^(ADDR_W-11) rows,
// and one duplicated bank set per read port. Every write is parked in a
// one-entry pending buffer. The buffer drains into all sets on bank port 0
// unless a read targets the pending address. In that case the drain stalls,
// the write port reports not-ready, and the read is served by merging the
// pending data over the bank data.
module unisim_sram_b_param_1wnr #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int NRD     = 2,
  parameter int OUT_REG = 0,
  parameter int CNT_W   = 16
) (
  input logic                        CLK,
  input logic                        RSTN,
  unisim_sram_b_param_1wnr_if.slave  bus
);

  localparam int NH     = DATA_W / 8;
  localparam int VB     = (ADDR_W > 11) ? (ADDR_W - 11) : 0;
  localparam int NV     = 1 << VB;
  localparam int VSEL_W = (VB > 0) ? VB : 1;

  if (((DATA_W % 8) != 0) || (DATA_W < 8) || (DATA_W > 64) ||
      (ADDR_W < 11) || (NRD < 1) || (NRD > 4)) begin : g_bad_param
    $fatal(1, "unisim_sram_b_param_1wnr: illegal DATA_W/ADDR_W/NRD");
  end

  // Row (vertical bank) index of an address: the bits above the 11 bank bits.
  function automatic logic [VSEL_W-1:0] vsel_of(input logic [ADDR_W-1:0] a);
    return VSEL_W'(a >> 4'd11);
  endfunction

  // Bit-masked merge: masked bits come from new_d, the rest from old_d.
  function automatic logic [DATA_W-1:0] mask_merge(input logic [DATA_W-1:0] new_d,
                                                   input logic [DATA_W-1:0] mask,
                                                   input logic [DATA_W-1:0] old_d);
    return (mask & new_d) | (~mask & old_d);
  endfunction

  // Pending write buffer.
  logic              pv_q, pv_d;
  logic [ADDR_W-1:0] pa_q, pa_d;
  logic [DATA_W-1:0] pd_q, pd_d;
  logic [DATA_W-1:0] pm_q, pm_d;

  // Hazard and handshake.
  logic [NRD-1:0]    hit_s;
  logic              blocked_s;
  logic              drain_s;
  logic              rdy_s;
  logic              accept_s;
  logic [VSEL_W-1:0] pa_vsel_s;

  // Per-read-port state.
  logic [ADDR_W-1:0] rd_addr_s [NRD];
  logic [VSEL_W-1:0] rd_vsel_s [NRD];
  logic [VSEL_W-1:0] vsel_q [NRD];
  logic [VSEL_W-1:0] vsel_d [NRD];
  logic [NRD-1:0]    rv_q, rv_d;
  logic [NRD-1:0]    fwd_q, fwd_d;
  logic [DATA_W-1:0] fpd_q [NRD];
  logic [DATA_W-1:0] fpd_d [NRD];
  logic [DATA_W-1:0] fpm_q [NRD];
  logic [DATA_W-1:0] fpm_d [NRD];

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0]     bank_q_s [NRD][NV];
  logic [DATA_W-1:0]     merged_s [NRD];
  logic [NRD*DATA_W-1:0] q_out_s;
  logic [NRD-1:0]        qv_out_s;

  // Split the packed read-address bus and detect hits on the pending address.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_addr_s[r] = bus.A1[r*ADDR_W +: ADDR_W];
      rd_vsel_s[r] = vsel_of(rd_addr_s[r]);
      if (pv_q && bus.CE1[r] && (rd_addr_s[r] == pa_q)) begin
        hit_s[r] = 1'b1;
      end else begin
        hit_s[r] = 1'b0;
      end
    end
  end

  // A drain is blocked whenever a live read targets the pending address.
  always_comb begin
    blocked_s = |hit_s;
    drain_s   = pv_q & ~blocked_s;
    rdy_s     = ~pv_q | ~blocked_s;
    accept_s  = bus.CE0 & bus.WE0 & rdy_s;
    pa_vsel_s = vsel_of(pa_q);
  end

  // Pending buffer next state: load on accept, clear on drain, else hold.
  always_comb begin
    pv_d = pv_q;
    pa_d = pa_q;
    pd_d = pd_q;
    pm_d = pm_q;
    if (accept_s) begin
      pv_d = 1'b1;
      pa_d = bus.A0;
      pd_d = bus.D0;
      pm_d = bus.WEM0;
    end else if (drain_s) begin
      pv_d = 1'b0;
    end else begin
      pv_d = pv_q;
    end
  end

  // Saturating count of blocked-drain cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (blocked_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Per-port read tracking: valid, row select and forward snapshot at issue.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rv_d[r]   = bus.CE1[r];
      vsel_d[r] = vsel_q[r];
      fwd_d[r]  = fwd_q[r];
      fpd_d[r]  = fpd_q[r];
      fpm_d[r]  = fpm_q[r];
      if (bus.CE1[r]) begin
        vsel_d[r] = rd_vsel_s[r];
        fwd_d[r]  = hit_s[r];
        fpd_d[r]  = pd_q;
        fpm_d[r]  = pm_q;
      end else begin
        vsel_d[r] = vsel_q[r];
      end
    end
  end

  // Control and read-tracking registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pv_q  <= 1'b0;
      pa_q  <= {ADDR_W{1'b0}};
      pd_q  <= {DATA_W{1'b0}};
      pm_q  <= {DATA_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      rv_q  <= {NRD{1'b0}};
      fwd_q <= {NRD{1'b0}};
      for (int r = 0; r < NRD; r++) begin
        vsel_q[r] <= {VSEL_W{1'b0}};
        fpd_q[r]  <= {DATA_W{1'b0}};
        fpm_q[r]  <= {DATA_W{1'b0}};
      end
    end else begin
      pv_q  <= pv_d;
      pa_q  <= pa_d;
      pd_q  <= pd_d;
      pm_q  <= pm_d;
      cnt_q <= cnt_d;
      rv_q  <= rv_d;
      fwd_q <= fwd_d;
      for (int r = 0; r < NRD; r++) begin
        vsel_q[r] <= vsel_d[r];
        fpd_q[r]  <= fpd_d[r];
        fpm_q[r]  <= fpm_d[r];
      end
    end
  end

  // Bank array: set r serves read port r; every set takes every drain.
  for (genvar r = 0; r < NRD; r++) begin : g_set
    for (genvar v = 0; v < NV; v++) begin : g_row
      logic [DATA_W-1:0] row_s;
      logic              wr_sel_s;

      assign wr_sel_s = drain_s && (pa_vsel_s == VSEL_W'(v));

      for (genvar h = 0; h < NH; h++) begin : g_col
        logic [7:0] mem [0:2047];
        logic [7:0] dout_q;

        // Bank port 0: bit-masked write of the draining entry.
        always_ff @(posedge CLK) begin
          if (wr_sel_s) begin
            mem[pa_q[10:0]] <= (mem[pa_q[10:0]] & ~pm_q[h*8 +: 8]) |
                               (pd_q[h*8 +: 8] & pm_q[h*8 +: 8]);
          end
        end

        // Bank port 1: read-first output latch, holds while the port is idle.
        always_ff @(posedge CLK or negedge RSTN) begin
          if (!RSTN) begin
            dout_q <= 8'd0;
          end else if (bus.CE1[r]) begin
            dout_q <= mem[rd_addr_s[r][10:0]];
          end
        end

        assign row_s[h*8 +: 8] = dout_q;
      end

      assign bank_q_s[r][v] = row_s;
    end
  end

  // Row select and forward merge of the bank output.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      if (fwd_q[r]) begin
        merged_s[r] = mask_merge(fpd_q[r], fpm_q[r], bank_q_s[r][vsel_q[r]]);
      end else begin
        merged_s[r] = bank_q_s[r][vsel_q[r]];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] oq_q [NRD];
    logic [DATA_W-1:0] oq_d [NRD];
    logic [NRD-1:0]    oqv_q, oqv_d;

    // Extra output stage loads only when data is valid, so Q1 holds otherwise.
    always_comb begin
      oqv_d = rv_q;
      for (int r = 0; r < NRD; r++) begin
        if (rv_q[r]) begin
          oq_d[r] = merged_s[r];
        end else begin
          oq_d[r] = oq_q[r];
        end
      end
    end

    // Output stage registers.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        oqv_q <= {NRD{1'b0}};
        for (int r = 0; r < NRD; r++) begin
          oq_q[r] <= {DATA_W{1'b0}};
        end
      end else begin
        oqv_q <= oqv_d;
        for (int r = 0; r < NRD; r++) begin
          oq_q[r] <= oq_d[r];
        end
      end
    end

    // Pack the registered stage onto the output bus.
    always_comb begin
      q_out_s  = {(NRD*DATA_W){1'b0}};
      qv_out_s = oqv_q;
      for (int r = 0; r < NRD; r++) begin
        q_out_s[r*DATA_W +: DATA_W] = oq_q[r];
      end
    end
  end else begin : g_out_comb
    // Pack the merged bank output directly; every source is a register.
    always_comb begin
      q_out_s  = {(NRD*DATA_W){1'b0}};
      qv_out_s = rv_q;
      for (int r = 0; r < NRD; r++) begin
        q_out_s[r*DATA_W +: DATA_W] = merged_s[r];
      end
    end
  end

  assign bus.RDY0         = rdy_s;
  assign bus.Q1           = q_out_s;
  assign bus.QV1          = qv_out_s;
  assign bus.CONFLICT_CNT = cnt_q;

endmodule

// File: tb/tb_unisim_sram_b_param_1wnr.sv
// Directed bench: a table of per-cycle vectors for the default configuration,
// plus hand sequences for row banking, 2-cycle latency with 4 ports, counter
// saturation and reset in the middle of a stalled write.
module tb_unisim_sram_b_param_1wnr;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  unisim_sram_b_param_1wnr_if #(.DATA_W(16), .ADDR_W(12), .NRD(2), .CNT_W(16)) ifa ();
  unisim_sram_b_param_1wnr_if #(.DATA_W(16), .ADDR_W(13), .NRD(4), .CNT_W(2))  ifb ();

  unisim_sram_b_param_1wnr #(.DATA_W(16), .ADDR_W(12), .NRD(2), .OUT_REG(0), .CNT_W(16)) dut_a (
    .CLK (clk),
    .RSTN(rst_n),
    .bus (ifa)
  );

  unisim_sram_b_param_1wnr #(.DATA_W(16), .ADDR_W(13), .NRD(4), .OUT_REG(1), .CNT_W(2)) dut_b (
    .CLK (clk),
    .RSTN(rst_n),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic        ce0;
    logic [11:0] a0;
    logic [15:0] d0;
    logic [15:0] wem0;
    logic [1:0]  ce1;
    logic [11:0] ra0;
    logic [11:0] ra1;
    logic        exp_rdy;
    logic [31:0] exp_q;
    logic [1:0]  exp_qv;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ce0, input logic [11:0] a0, input logic [15:0] d0,
                              input logic [15:0] wem0, input logic [1:0] ce1,
                              input logic [11:0] ra0, input logic [11:0] ra1,
                              input logic rdy, input logic [31:0] q, input logic [1:0] qv,
                              input logic [15:0] cnt);
    vec_t v;
    v.ce0 = ce0; v.a0 = a0; v.d0 = d0; v.wem0 = wem0; v.ce1 = ce1;
    v.ra0 = ra0; v.ra1 = ra1; v.exp_rdy = rdy; v.exp_q = q; v.exp_qv = qv; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic a_set(input logic ce0, input logic [11:0] a0, input logic [15:0] d0,
                       input logic [15:0] wem0, input logic [1:0] ce1,
                       input logic [11:0] ra0, input logic [11:0] ra1);
    ifa.CE0  = ce0;
    ifa.WE0  = ce0;
    ifa.A0   = a0;
    ifa.D0   = d0;
    ifa.WEM0 = wem0;
    ifa.CE1  = ce1;
    ifa.A1   = {ra1, ra0};
  endtask

  task automatic b_cyc(input logic ce0, input logic [12:0] a0, input logic [15:0] d0,
                       input logic [3:0] ce1, input logic [12:0] ra0, input logic [12:0] ra1,
                       input logic [12:0] ra2, input logic [12:0] ra3, output logic rdy);
    ifb.CE0  = ce0;
    ifb.WE0  = ce0;
    ifb.A0   = a0;
    ifb.D0   = d0;
    ifb.WEM0 = 16'hFFFF;
    ifb.CE1  = ce1;
    ifb.A1   = {ra3, ra2, ra1, ra0};
    #1;
    rdy = ifb.RDY0;
    @(posedge clk);
    #1;
  endtask

  logic b_rdy;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a_set(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000);
    ifb.CE0 = 1'b0; ifb.WE0 = 1'b0; ifb.A0 = 13'h0000; ifb.D0 = 16'h0000;
    ifb.WEM0 = 16'h0000; ifb.CE1 = 4'b0000; ifb.A1 = 52'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_q",    64'(ifa.Q1), 64'h0);
    chk("reset_a_qv",   64'(ifa.QV1), 64'h0);
    chk("reset_a_rdy",  64'(ifa.RDY0), 64'h1);
    chk("reset_a_cnt",  64'(ifa.CONFLICT_CNT), 64'h0);
    chk("reset_b_qv",   64'(ifb.QV1), 64'h0);
    chk("reset_b_q",    64'(ifb.Q1), 64'h0);
    rst_n = 1'b1;

    //            ce0   a0       d0        wem0      ce1    ra0      ra1      rdy   q              qv     cnt
    vecs.push_back(mk(1'b1, 12'h005, 16'hBEEF, 16'hFFFF, 2'b00, 12'h000, 12'h000, 1'b1, 32'h0000_0000, 2'b00, 16'd0));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000, 1'b1, 32'h0000_0000, 2'b00, 16'd0));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b01, 12'h005, 12'h000, 1'b1, 32'h0000_BEEF, 2'b01, 16'd0));
    vecs.push_back(mk(1'b1, 12'h010, 16'h1111, 16'hFFFF, 2'b00, 12'h000, 12'h000, 1'b1, 32'h0000_BEEF, 2'b00, 16'd0));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000, 1'b1, 32'h0000_BEEF, 2'b00, 16'd0));
    vecs.push_back(mk(1'b1, 12'h010, 16'h2222, 16'hFFFF, 2'b10, 12'h000, 12'h010, 1'b1, 32'h1111_BEEF, 2'b10, 16'd0));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b10, 12'h000, 12'h010, 1'b0, 32'h2222_BEEF, 2'b10, 16'd1));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000, 1'b1, 32'h2222_BEEF, 2'b00, 16'd1));
    vecs.push_back(mk(1'b1, 12'h020, 16'hAB00, 16'hFFFF, 2'b00, 12'h000, 12'h000, 1'b1, 32'h2222_BEEF, 2'b00, 16'd1));
    vecs.push_back(mk(1'b1, 12'h020, 16'h00FF, 16'h00FF, 2'b00, 12'h000, 12'h000, 1'b1, 32'h2222_BEEF, 2'b00, 16'd1));
    vecs.push_back(mk(1'b1, 12'h030, 16'h1234, 16'hFFFF, 2'b11, 12'h020, 12'h020, 1'b0, 32'hABFF_ABFF, 2'b11, 16'd2));
    vecs.push_back(mk(1'b1, 12'h030, 16'h1234, 16'hFFFF, 2'b11, 12'h020, 12'h020, 1'b0, 32'hABFF_ABFF, 2'b11, 16'd3));
    vecs.push_back(mk(1'b1, 12'h030, 16'h1234, 16'hFFFF, 2'b00, 12'h000, 12'h000, 1'b1, 32'hABFF_ABFF, 2'b00, 16'd3));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b11, 12'h020, 12'h005, 1'b1, 32'hBEEF_ABFF, 2'b11, 16'd3));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b01, 12'h030, 12'h000, 1'b1, 32'hBEEF_1234, 2'b01, 16'd3));
    vecs.push_back(mk(1'b1, 12'h030, 16'hFFFF, 16'h0000, 2'b00, 12'h000, 12'h000, 1'b1, 32'hBEEF_1234, 2'b00, 16'd3));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000, 1'b1, 32'hBEEF_1234, 2'b00, 16'd3));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b10, 12'h000, 12'h030, 1'b1, 32'h1234_1234, 2'b10, 16'd3));
    vecs.push_back(mk(1'b1, 12'h805, 16'h5A5A, 16'hFFFF, 2'b00, 12'h000, 12'h000, 1'b1, 32'h1234_1234, 2'b00, 16'd3));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000, 1'b1, 32'h1234_1234, 2'b00, 16'd3));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b11, 12'h805, 12'h005, 1'b1, 32'hBEEF_5A5A, 2'b11, 16'd3));

    for (int i = 0; i < vecs.size(); i++) begin
      a_set(vecs[i].ce0, vecs[i].a0, vecs[i].d0, vecs[i].wem0, vecs[i].ce1, vecs[i].ra0, vecs[i].ra1);
      #1;
      chk($sformatf("a_v%0d_rdy", i), 64'(ifa.RDY0), 64'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("a_v%0d_q", i),   64'(ifa.Q1), 64'(vecs[i].exp_q));
      chk($sformatf("a_v%0d_qv", i),  64'(ifa.QV1), 64'(vecs[i].exp_qv));
      chk($sformatf("a_v%0d_cnt", i), 64'(ifa.CONFLICT_CNT), 64'(vecs[i].exp_cnt));
    end
    a_set(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000);

    // Row banking on a 13-bit, 4-port, registered-output instance.
    b_cyc(1'b1, 13'h1800, 16'hC001, 4'b0000, 13'h0, 13'h0, 13'h0, 13'h0, b_rdy);
    b_cyc(1'b1, 13'h0800, 16'h0B0B, 4'b0000, 13'h0, 13'h0, 13'h0, 13'h0, b_rdy);
    b_cyc(1'b0, 13'h0000, 16'h0000, 4'b0000, 13'h0, 13'h0, 13'h0, 13'h0, b_rdy);
    b_cyc(1'b0, 13'h0000, 16'h0000, 4'b1011, 13'h1800, 13'h0800, 13'h0000, 13'h1800, b_rdy);
    chk("b_lat_t1_qv", 64'(ifb.QV1), 64'h0);
    chk("b_lat_t1_q",  64'(ifb.Q1), 64'h0);
    b_cyc(1'b0, 13'h0000, 16'h0000, 4'b0111, 13'h0800, 13'h1800, 13'h0800, 13'h0000, b_rdy);
    chk("b_rd1_qv", 64'(ifb.QV1), 64'hB);
    chk("b_rd1_q",  64'(ifb.Q1), 64'hC001_0000_0B0B_C001);
    b_cyc(1'b0, 13'h0000, 16'h0000, 4'b0000, 13'h0, 13'h0, 13'h0, 13'h0, b_rdy);
    chk("b_rd2_qv", 64'(ifb.QV1), 64'h7);
    chk("b_rd2_q",  64'(ifb.Q1), 64'hC001_0B0B_C001_0B0B);
    b_cyc(1'b0, 13'h0000, 16'h0000, 4'b0000, 13'h0, 13'h0, 13'h0, 13'h0, b_rdy);
    chk("b_idle_qv",   64'(ifb.QV1), 64'h0);
    chk("b_idle_hold", 64'(ifb.Q1), 64'hC001_0B0B_C001_0B0B);

    // Repeated blocking: the 2-bit counter saturates at 3.
    b_cyc(1'b1, 13'h0100, 16'h0001, 4'b0000, 13'h0, 13'h0, 13'h0, 13'h0, b_rdy);
    chk("b_sat_acc_rdy", 64'(b_rdy), 64'h1);
    for (int k = 1; k <= 4; k++) begin
      b_cyc(1'b0, 13'h0000, 16'h0000, 4'b0100, 13'h0, 13'h0, 13'h0100, 13'h0, b_rdy);
      chk($sformatf("b_sat%0d_rdy", k), 64'(b_rdy), 64'h0);
      chk($sformatf("b_sat%0d_cnt", k), 64'(ifb.CONFLICT_CNT), 64'((k > 3) ? 3 : k));
      if (k >= 2) begin
        chk($sformatf("b_sat%0d_fwd", k), 64'(ifb.Q1[47:32]), 64'h0001);
      end
    end
    b_cyc(1'b0, 13'h0000, 16'h0000, 4'b0000, 13'h0, 13'h0, 13'h0, 13'h0, b_rdy);
    chk("b_sat_drain_rdy", 64'(b_rdy), 64'h1);
    chk("b_sat_drain_cnt", 64'(ifb.CONFLICT_CNT), 64'h3);

    // Reset while a write is stalled behind a read in flight.
    a_set(1'b1, 12'h040, 16'h4444, 16'hFFFF, 2'b00, 12'h000, 12'h000);
    @(posedge clk); #1;
    a_set(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000);
    @(posedge clk); #1;
    a_set(1'b1, 12'h040, 16'h7777, 16'hFFFF, 2'b00, 12'h000, 12'h000);
    @(posedge clk); #1;
    a_set(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b01, 12'h040, 12'h000);
    #1;
    chk("rst_pre_rdy", 64'(ifa.RDY0), 64'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_a_q",   64'(ifa.Q1), 64'h0);
    chk("rst_a_qv",  64'(ifa.QV1), 64'h0);
    chk("rst_a_rdy", 64'(ifa.RDY0), 64'h1);
    chk("rst_a_cnt", 64'(ifa.CONFLICT_CNT), 64'h0);
    chk("rst_b_cnt", 64'(ifb.CONFLICT_CNT), 64'h0);
    chk("rst_b_q",   64'(ifb.Q1), 64'h0);
    a_set(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_set(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b01, 12'h040, 12'h000);
    @(posedge clk); #1;
    chk("rst_after_q",  64'(ifa.Q1), 64'h0000_4444);
    chk("rst_after_qv", 64'(ifa.QV1), 64'h1);
    a_set(1'b0, 12'h000, 16'h0000, 16'h0000, 2'b00, 12'h000, 12'h000);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
